// File: rtl/sseg_scan_decoder.sv
// Seven-segment scan bus decoder: captures stable active-low digit/segment dwells into hex slots.
// Optional 2-flop input synchronizer enabled by defining SSEG_SCAN_DECODER_SYNC_EN.
module sseg_scan_decoder #(
  parameter int N_DIGITS      = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_DIGITS-1:0]   an,
  input  logic [7:0]            sseg,
  output logic [4*N_DIGITS-1:0] hex_out,
  output logic [N_DIGITS-1:0]   dp_out,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  err_pulse,
  output logic [2:0]            err_digit,
  output logic                  frame_done
);

  localparam int RW = N_DIGITS + 8;
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_COUNT, ST_DONE} state_t;

  // Returns {match, value}; match=0 for any pattern outside the hex table.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode_seg = {1'b1, 4'h0};
      7'b1111001: decode_seg = {1'b1, 4'h1};
      7'b0100100: decode_seg = {1'b1, 4'h2};
      7'b0110000: decode_seg = {1'b1, 4'h3};
      7'b0011001: decode_seg = {1'b1, 4'h4};
      7'b0010010: decode_seg = {1'b1, 4'h5};
      7'b0000010: decode_seg = {1'b1, 4'h6};
      7'b1111000: decode_seg = {1'b1, 4'h7};
      7'b0000000: decode_seg = {1'b1, 4'h8};
      7'b0010000: decode_seg = {1'b1, 4'h9};
      7'b0001000: decode_seg = {1'b1, 4'hA};
      7'b0000011: decode_seg = {1'b1, 4'hB};
      7'b1000110: decode_seg = {1'b1, 4'hC};
      7'b0100001: decode_seg = {1'b1, 4'hD};
      7'b0000110: decode_seg = {1'b1, 4'hE};
      7'b0001110: decode_seg = {1'b1, 4'hF};
      default:    decode_seg = 5'b0_0000;
    endcase
  endfunction

  logic [RW-1:0]         r_in;
  logic [RW-1:0]         r_q, rp_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  state_t                state_q, state_d;
  logic [4*N_DIGITS-1:0] hex_q, hex_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d, valid_q, valid_d, seen_q, seen_d;
  logic                  err_q, err_d, frame_q, frame_d;
  logic [2:0]            err_digit_q, err_digit_d;

`ifdef SSEG_SCAN_DECODER_SYNC_EN
  logic [RW-1:0] s1_q, s2_q, s1_d, s2_d;

  assign s1_d = {an, sseg};
  assign s2_d = s1_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
  assign r_in = s2_q;
`else
  assign r_in = {an, sseg};
`endif

  logic                same, one_hot, capture, blank;
  logic [N_DIGITS-1:0] an_r;
  logic [7:0]          seg_r;
  logic [2:0]          idx;
  logic [4:0]          dec;

  always_comb begin
    an_r    = r_q[RW-1:8];
    seg_r   = r_q[7:0];
    same    = (r_q == rp_q);
    one_hot = $onehot(~an_r);
    idx     = 3'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!an_r[i]) idx = 3'(i);
    end
    dec     = decode_seg(seg_r[6:0]);
    blank   = (seg_r[6:0] == 7'h7F);

    cnt_d   = same ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1) : '0;

    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_WAIT:  if (same && one_hot) state_d = ST_COUNT;
      ST_COUNT: begin
        if (!same || !one_hot) begin
          state_d = ST_WAIT;
        end else if (cnt_q == CNT_MAX) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE:  if (!same) state_d = ST_WAIT;
      default:  state_d = ST_WAIT;
    endcase

    hex_d       = hex_q;
    dp_d        = dp_q;
    valid_d     = valid_q;
    seen_d      = seen_q;
    err_d       = 1'b0;
    err_digit_d = err_digit_q;
    frame_d     = 1'b0;
    if (capture) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (idx == 3'(i)) begin
          dp_d[i]    = ~seg_r[7];
          valid_d[i] = dec[4];
          seen_d[i]  = 1'b1;
          if (dec[4]) hex_d[4*i +: 4] = dec[3:0];
        end
      end
      if (!dec[4] && !blank) begin
        err_d       = 1'b1;
        err_digit_d = idx;
      end
      // Frame completes on the capture that fills the seen mask; start a new frame.
      if (&seen_d) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q         <= '1;
      rp_q        <= '1;
      cnt_q       <= '0;
      state_q     <= ST_WAIT;
      hex_q       <= '0;
      dp_q        <= '0;
      valid_q     <= '0;
      seen_q      <= '0;
      err_q       <= 1'b0;
      err_digit_q <= 3'd0;
      frame_q     <= 1'b0;
    end else begin
      r_q         <= r_in;
      rp_q        <= r_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      hex_q       <= hex_d;
      dp_q        <= dp_d;
      valid_q     <= valid_d;
      seen_q      <= seen_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
      frame_q     <= frame_d;
    end
  end

  assign hex_out     = hex_q;
  assign dp_out      = dp_q;
  assign digit_valid = valid_q;
  assign err_pulse   = err_q;
  assign err_digit   = err_digit_q;
  assign frame_done  = frame_q;

endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder.
- Monitors a time-multiplexed, active-low seven-segment display bus (digit enables plus segment pattern) and decodes each stable pattern back to a 4-bit hex value.
- Assembles the decoded digits into a multi-digit register.
- Used as a display loopback checker and as a capture front-end for external seven-segment sources.

Parameters:
- N_DIGITS, 8, number of multiplexed digit positions (an width), 1..8.
- STABLE_CYCLES, 16, consecutive identical samples required before a dwell is accepted, ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- an  in  N_DIGITS  digit enables, active-low; bit i selects digit i.
- sseg  in  8  segments, active-low; bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
- hex_out  out  4*N_DIGITS  decoded digits; digit i at bits 4i+3..4i.
- dp_out  out  N_DIGITS  decimal point per digit, active-high (1 = lit).
- digit_valid  out  N_DIGITS  1 = slot holds a successfully decoded hex value.
- err_pulse  out  1  one-cycle pulse: stable pattern matched no hex code and was not blank.
- err_digit  out  3  slot index of the last error; held until the next error.
- frame_done  out  1  one-cycle pulse: every slot captured at least once since the previous pulse.

Behaviour:
- Reset (async, active-high): hex_out=0, dp_out=0, digit_valid=0, err_pulse=0, err_digit=0, frame_done=0, seen mask=0, FSM=WAIT, counter=0, input registers=all-ones (idle bus).
- Input register r = {an, sseg}, sampled every clk. r_prev holds the previous sample.
- Counter rules:
  - Cleared to 0 whenever r != r_prev.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- one_hot = exactly one bit of an low.
- FSM:
  - WAIT: on r==r_prev and one_hot -> COUNT.
  - COUNT:
    - If r != r_prev or !one_hot -> WAIT.
    - When counter reaches STABLE_CYCLES-1 with r==r_prev -> perform capture, go to DONE.
  - DONE: hold (at most one capture per dwell) until r != r_prev -> WAIT.
- Capture for digit index i (position of the low an bit):
  - Pattern in the 16-entry standard hex table (0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110; g..a) -> hex slot i = value, digit_valid[i]=1.
  - Blank pattern 1111111 -> digit_valid[i]=0, hex slot unchanged, no error.
  - Any other pattern -> digit_valid[i]=0, err_pulse=1 for one cycle, err_digit=i.
  - In all three cases: dp_out[i]=~sseg[7], and seen[i] is set.
- Capture latency: outputs update on the (STABLE_CYCLES+1)th rising edge after the edge that first loads the new value into r.
- Glitch rule: a dwell shorter than STABLE_CYCLES samples produces no update and no error.
- frame_done:
  - When a capture makes seen all-ones, frame_done pulses in the same cycle as the slot update, and seen clears to 0.
  - Repeated captures of an already-seen slot do not advance the frame.
- Ignored inputs: an all-high or with multiple bits low; an bits at or above N_DIGITS are ignored.
- Reset mid-dwell: reset aborts the dwell; after release, a full STABLE_CYCLES dwell is required again.

Optional Feature:
- Macro: SSEG_SCAN_DECODER_SYNC_EN.
- Defined: an and sseg pass through a 2-flop synchronizer (reset to all-ones) before r. Capture latency is +2 cycles.
- Undefined: inputs feed r directly, for on-chip loopback from a synchronous driver.

Test Plan:
- Decode table: an=11111110, sseg cycles through all 16 table patterns, each held 20 cycles, dp off -> hex_out[3:0] tracks 0..F; digit_valid[0]=1; err_pulse never asserted.
- Full frame: scan digits 0..7 showing 0..7 with dp lit on digit 3, 20 cycles each -> hex_out=0x76543210, dp_out=0x08, digit_valid=0xFF, exactly one frame_done pulse on the digit-7 capture.
- Invalid pattern: an=11011111, sseg=0x77 (1110111) held 20 cycles -> single err_pulse, err_digit=5, digit_valid[5]=0, hex slot 5 unchanged.
- Glitch reject: stable digit 2 = "3" captured, then sseg=0x99 for 10 cycles, then back -> hex slot 2 stays 3, no error, no second capture.
- Illegal enables: an=11111100 or 11111111 for 40 cycles with a valid pattern -> no output change.
- Reset mid-dwell: assert reset at cycle 8 of a dwell -> all outputs zero asynchronously; after release the held pattern captures exactly STABLE_CYCLES+1 edges later.
